// File: rtl/cc_collision_tracker.sv
// Registered per-player collision tracker: overlap of each position mask with the
// bottom obstacle row drives hit pulses, life counters, grace windows and game-over flags.
module cc_collision_tracker #(
    parameter int PosCOMPARATOR_DATAWIDTH = 8,
    parameter int NUM_PLAYERS             = 2,
    parameter int LIVES_INIT              = 3,
    parameter int GRACE_STROBES           = 4,
    localparam int LW = $clog2(LIVES_INIT + 1),
    localparam int GW = (GRACE_STROBES > 0) ? $clog2(GRACE_STROBES + 1) : 1
) (
    input  logic                                       CC_COLLISIONTRACKER_CLOCK_50,
    input  logic                                       CC_COLLISIONTRACKER_RESET_InLow,
    input  logic [PosCOMPARATOR_DATAWIDTH-1:0]             CC_COLLISIONTRACKER_fila0,
    input  logic [NUM_PLAYERS*PosCOMPARATOR_DATAWIDTH-1:0] CC_COLLISIONTRACKER_posjug,
    input  logic                                       CC_COLLISIONTRACKER_strobe,
    input  logic                                       CC_COLLISIONTRACKER_clear,
    output logic [NUM_PLAYERS-1:0]                     CC_COLLISIONTRACKER_NoHit_OutBUS,
    output logic [NUM_PLAYERS-1:0]                     CC_COLLISIONTRACKER_hit,
    output logic [NUM_PLAYERS*LW-1:0]                  CC_COLLISIONTRACKER_lives,
    output logic [NUM_PLAYERS-1:0]                     CC_COLLISIONTRACKER_gameover,
    output logic                                       CC_COLLISIONTRACKER_allover
);
    // state  | meaning
    // ALIVE  | overlaps on a strobe cost a life
    // GRACE  | post-hit window, overlaps ignored, counter runs down per strobe
    // DEAD   | no lives left, absorbing until clear or reset
    localparam logic [1:0] ST_ALIVE = 2'd0;
    localparam logic [1:0] ST_GRACE = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    localparam int W = PosCOMPARATOR_DATAWIDTH;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [1:0]    state_q, state_d;
        logic [LW-1:0] lives_q, lives_d;
        logic [GW-1:0] cnt_q, cnt_d;
        logic          hit_q, hit_d;
        logic          nohit_q, nohit_d;
        logic          ov;

        assign ov = |(CC_COLLISIONTRACKER_fila0 & CC_COLLISIONTRACKER_posjug[p*W +: W]);

        always_comb begin
            state_d = state_q;
            lives_d = lives_q;
            cnt_d   = cnt_q;
            hit_d   = 1'b0;
            nohit_d = nohit_q;
            if (CC_COLLISIONTRACKER_clear) begin
                state_d = ST_ALIVE;
                lives_d = LW'(LIVES_INIT);
                cnt_d   = '0;
                nohit_d = 1'b1;
            end else if (CC_COLLISIONTRACKER_strobe) begin
                nohit_d = ~ov;
                case (state_q)
                    ST_ALIVE: begin
                        if (ov) begin
                            hit_d   = 1'b1;
                            lives_d = lives_q - LW'(1);
                            if (lives_q == LW'(1)) begin
                                state_d = ST_DEAD;
                            end else if (GRACE_STROBES > 0) begin
                                state_d = ST_GRACE;
                                cnt_d   = GW'(GRACE_STROBES);
                            end
                        end
                    end
                    ST_GRACE: begin
                        cnt_d = (cnt_q == '0) ? '0 : cnt_q - GW'(1);
                        if (cnt_q <= GW'(1)) state_d = ST_ALIVE;
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge CC_COLLISIONTRACKER_CLOCK_50 or negedge CC_COLLISIONTRACKER_RESET_InLow) begin
            if (!CC_COLLISIONTRACKER_RESET_InLow) begin
                state_q <= ST_ALIVE;
                lives_q <= LW'(LIVES_INIT);
                cnt_q   <= '0;
                hit_q   <= 1'b0;
                nohit_q <= 1'b1;
            end else begin
                state_q <= state_d;
                lives_q <= lives_d;
                cnt_q   <= cnt_d;
                hit_q   <= hit_d;
                nohit_q <= nohit_d;
            end
        end

        assign CC_COLLISIONTRACKER_NoHit_OutBUS[p]     = nohit_q;
        assign CC_COLLISIONTRACKER_hit[p]              = hit_q;
        assign CC_COLLISIONTRACKER_lives[p*LW +: LW]   = lives_q;
        assign CC_COLLISIONTRACKER_gameover[p]         = (state_q == ST_DEAD);
    end

    assign CC_COLLISIONTRACKER_allover = &CC_COLLISIONTRACKER_gameover;

endmodule

// File: tb/tb_cc_collision_tracker.sv
// Directed bench for cc_collision_tracker: a vector table for the main game flow on
// the default build, plus hand sequences for a no-grace build and asynchronous reset.
module tb_cc_collision_tracker;
    localparam int W  = 8;
    localparam int N  = 2;
    localparam int LW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   fila = '0;
    logic [N*W-1:0] pos = '0;
    logic           strobe = 1'b0;
    logic           clear = 1'b0;

    logic [N-1:0]    a_nohit, a_hit, a_go, b_nohit, b_hit, b_go;
    logic [N*LW-1:0] a_lives, b_lives;
    logic            a_all, b_all;

    cc_collision_tracker #(.PosCOMPARATOR_DATAWIDTH(W), .NUM_PLAYERS(N),
                           .LIVES_INIT(3), .GRACE_STROBES(4)) dut_a (
        .CC_COLLISIONTRACKER_CLOCK_50     (clk),
        .CC_COLLISIONTRACKER_RESET_InLow  (rst_n),
        .CC_COLLISIONTRACKER_fila0        (fila),
        .CC_COLLISIONTRACKER_posjug       (pos),
        .CC_COLLISIONTRACKER_strobe       (strobe),
        .CC_COLLISIONTRACKER_clear        (clear),
        .CC_COLLISIONTRACKER_NoHit_OutBUS (a_nohit),
        .CC_COLLISIONTRACKER_hit          (a_hit),
        .CC_COLLISIONTRACKER_lives        (a_lives),
        .CC_COLLISIONTRACKER_gameover     (a_go),
        .CC_COLLISIONTRACKER_allover      (a_all)
    );

    cc_collision_tracker #(.PosCOMPARATOR_DATAWIDTH(W), .NUM_PLAYERS(N),
                           .LIVES_INIT(3), .GRACE_STROBES(0)) dut_b (
        .CC_COLLISIONTRACKER_CLOCK_50     (clk),
        .CC_COLLISIONTRACKER_RESET_InLow  (rst_n),
        .CC_COLLISIONTRACKER_fila0        (fila),
        .CC_COLLISIONTRACKER_posjug       (pos),
        .CC_COLLISIONTRACKER_strobe       (strobe),
        .CC_COLLISIONTRACKER_clear        (clear),
        .CC_COLLISIONTRACKER_NoHit_OutBUS (b_nohit),
        .CC_COLLISIONTRACKER_hit          (b_hit),
        .CC_COLLISIONTRACKER_lives        (b_lives),
        .CC_COLLISIONTRACKER_gameover     (b_go),
        .CC_COLLISIONTRACKER_allover      (b_all)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   fila;
        logic [N*W-1:0] pos;
        logic           stb;
        logic           clr;
        logic [N-1:0]   hit;
        logic [N-1:0]   nohit;
        logic [N*LW-1:0] lives;
        logic [N-1:0]   go;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic [W-1:0] f, input logic [N*W-1:0] p,
                                input logic s, input logic c, input logic [N-1:0] h,
                                input logic [N-1:0] nh, input logic [N*LW-1:0] l,
                                input logic [N-1:0] g);
        vec_t v;
        v.fila = f; v.pos = p; v.stb = s; v.clr = c;
        v.hit = h; v.nohit = nh; v.lives = l; v.go = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [N-1:0] h, input logic [N-1:0] nh,
                           input logic [N*LW-1:0] l, input logic [N-1:0] g);
        chk({tag, " a.hit"}, 32'(a_hit), 32'(h));
        chk({tag, " a.nohit"}, 32'(a_nohit), 32'(nh));
        chk({tag, " a.lives"}, 32'(a_lives), 32'(l));
        chk({tag, " a.gameover"}, 32'(a_go), 32'(g));
        chk({tag, " a.allover"}, 32'(a_all), 32'(&g));
    endtask

    task automatic check_b(input string tag, input logic [N-1:0] h, input logic [N-1:0] nh,
                           input logic [N*LW-1:0] l, input logic [N-1:0] g);
        chk({tag, " b.hit"}, 32'(b_hit), 32'(h));
        chk({tag, " b.nohit"}, 32'(b_nohit), 32'(nh));
        chk({tag, " b.lives"}, 32'(b_lives), 32'(l));
        chk({tag, " b.gameover"}, 32'(b_go), 32'(g));
        chk({tag, " b.allover"}, 32'(b_all), 32'(&g));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic [W-1:0] f, input logic [N*W-1:0] p,
                        input logic s, input logic c);
        @(negedge clk);
        fila = f; pos = p; strobe = s; clear = c;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        clear  = 1'b0;
    endtask

    initial begin
        // lives packing is {p1, p0}, two bits each
        vecs[0]  = mk(8'h0F, 16'h1001, 1, 0, 2'b01, 2'b10, 4'hE, 2'b00);
        vecs[1]  = mk(8'h0F, 16'h1001, 0, 0, 2'b00, 2'b10, 4'hE, 2'b00);
        vecs[2]  = mk(8'h0F, 16'h1001, 1, 0, 2'b00, 2'b10, 4'hE, 2'b00);
        vecs[3]  = mk(8'h0F, 16'h1001, 1, 0, 2'b00, 2'b10, 4'hE, 2'b00);
        vecs[4]  = mk(8'h0F, 16'h1001, 1, 0, 2'b00, 2'b10, 4'hE, 2'b00);
        vecs[5]  = mk(8'h0F, 16'h1001, 1, 0, 2'b00, 2'b10, 4'hE, 2'b00);
        vecs[6]  = mk(8'h0F, 16'h1001, 1, 0, 2'b01, 2'b10, 4'hD, 2'b00);
        vecs[7]  = mk(8'h0F, 16'h0280, 1, 0, 2'b10, 2'b01, 4'h9, 2'b00);
        vecs[8]  = mk(8'h00, 16'h0280, 1, 0, 2'b00, 2'b11, 4'h9, 2'b00);
        vecs[9]  = mk(8'h00, 16'h0280, 1, 0, 2'b00, 2'b11, 4'h9, 2'b00);
        vecs[10] = mk(8'h00, 16'h0280, 1, 0, 2'b00, 2'b11, 4'h9, 2'b00);
        vecs[11] = mk(8'hFF, 16'h0101, 1, 0, 2'b01, 2'b00, 4'h8, 2'b01);
        vecs[12] = mk(8'hFF, 16'h0101, 1, 0, 2'b10, 2'b00, 4'h4, 2'b01);
        vecs[13] = mk(8'h00, 16'h0101, 1, 0, 2'b00, 2'b11, 4'h4, 2'b01);
        vecs[14] = mk(8'h00, 16'h0101, 1, 0, 2'b00, 2'b11, 4'h4, 2'b01);
        vecs[15] = mk(8'h00, 16'h0101, 1, 0, 2'b00, 2'b11, 4'h4, 2'b01);
        vecs[16] = mk(8'h00, 16'h0101, 1, 0, 2'b00, 2'b11, 4'h4, 2'b01);
        vecs[17] = mk(8'hFF, 16'h0101, 1, 0, 2'b10, 2'b00, 4'h0, 2'b11);
        vecs[18] = mk(8'hFF, 16'h0101, 1, 0, 2'b00, 2'b00, 4'h0, 2'b11);
        vecs[19] = mk(8'hFF, 16'h0101, 1, 1, 2'b00, 2'b11, 4'hF, 2'b00);
        vecs[20] = mk(8'h0F, 16'h1001, 1, 0, 2'b01, 2'b10, 4'hE, 2'b00);
        vecs[21] = mk(8'h00, 16'h0000, 0, 1, 2'b00, 2'b11, 4'hF, 2'b00);

        #12;
        check_a("reset", 2'b00, 2'b11, 4'hF, 2'b00);
        check_b("reset", 2'b00, 2'b11, 4'hF, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].fila, vecs[i].pos, vecs[i].stb, vecs[i].clr);
            check_a($sformatf("vec%0d", i), vecs[i].hit, vecs[i].nohit, vecs[i].lives, vecs[i].go);
        end

        // No-grace build: three consecutive overlapping strobes are three hits.
        step(8'h01, 16'h0001, 1, 0);
        check_b("nograce1", 2'b01, 2'b10, 4'hE, 2'b00);
        check_a("grace1", 2'b01, 2'b10, 4'hE, 2'b00);
        step(8'h01, 16'h0001, 1, 0);
        check_b("nograce2", 2'b01, 2'b10, 4'hD, 2'b00);
        check_a("grace2", 2'b00, 2'b10, 4'hE, 2'b00);
        step(8'h01, 16'h0001, 1, 0);
        check_b("nograce3", 2'b01, 2'b10, 4'hC, 2'b01);
        check_a("grace3", 2'b00, 2'b10, 4'hE, 2'b00);

        // Asynchronous reset mid-grace, checked before any further clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_rst", 2'b00, 2'b11, 4'hF, 2'b00);
        check_b("async_rst", 2'b00, 2'b11, 4'hF, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h0F, 16'h1001, 1, 0);
        check_a("post_rst", 2'b01, 2'b10, 4'hE, 2'b00);
        check_b("post_rst", 2'b01, 2'b10, 4'hE, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
